// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN
    } state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin priority select: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic found;
    int   idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between N byte streams,
// with per-message locking and a stalled-owner timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [N-1:0]      req_valid,
    input  logic [8*N-1:0]    req_data,
    input  logic [N-1:0]      req_last,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      grant,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_we,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state, state_nx;
    logic [N-1:0]      grant_nx, pick;
    logic [PW-1:0]     rr_ptr, rr_nx, owner, owner_nx, pick_idx, adv;
    logic [CW-1:0]     tcnt, tcnt_nx;
    logic              last_f, last_nx, hold, hold_nx;
    logic [BYTE_W-1:0] bytes [N];

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            bytes[i] = req_data[i*BYTE_W +: BYTE_W];
    end

    assign adv  = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
    assign busy = |grant;

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        owner_nx  = owner;
        rr_nx     = rr_ptr;
        tcnt_nx   = tcnt;
        last_nx   = last_f;
        hold_nx   = 1'b0;
        req_ready = '0;
        tx_we     = 1'b0;
        tx_data   = '0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_nx = pick;
                    owner_nx = pick_idx;
                    tcnt_nx  = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                // acceptance is checked first so it wins over expiry
                if (req_valid[owner]) begin
                    if (tx_ready && !wb_rst) begin
                        tx_we            = 1'b1;
                        tx_data          = bytes[owner];
                        req_ready[owner] = 1'b1;
                        last_nx          = req_last[owner];
                        tcnt_nx          = '0;
                        hold_nx          = 1'b1;
                        state_nx         = DRAIN;
                    end
                end else if (TO_EN) begin
                    if (tcnt == TLIM) begin
                        grant_nx = '0;
                        rr_nx    = adv;
                        tcnt_nx  = '0;
                        state_nx = IDLE;
                    end else if (tcnt != '1) begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // first cycle ignores tx_ready: uart_tx lowers it a cycle late
                if (!hold && tx_ready) begin
                    if (last_f) begin
                        grant_nx = '0;
                        rr_nx    = adv;
                        state_nx = IDLE;
                    end else begin
                        state_nx = SEND;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            tcnt   <= '0;
            last_f <= 1'b0;
            hold   <= 1'b0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_nx;
            tcnt   <= tcnt_nx;
            last_f <= last_nx;
            hold   <= hold_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: behavioural uart_tx and line decoder, a
// message-level round-robin model, and directed timeout/reset cases.
module tb_uart_tx_arb;

    localparam int N   = 3;
    localparam int TO  = 16;
    localparam int DIV = 4;

    logic           wb_clk = 1'b0;
    logic           wb_rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready, grant;
    logic [7:0]     tx_data;
    logic           tx_we, busy;
    logic           tx_ready = 1'b1;

    always #5 wb_clk = ~wb_clk;

    uart_tx_arb #(.N(N), .TIMEOUT(TO)) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_we     (tx_we),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    // uart_tx stand-in: 10-bit frame, DIV clocks per bit, never reset
    logic       u_busy = 1'b0;
    logic       u_line = 1'b1;
    logic [9:0] u_sh = '0;
    int         u_div = 0;
    int         u_bit = 0;

    always @(posedge wb_clk) begin
        if (u_busy) begin
            if (u_div == DIV - 1) begin
                u_div <= 0;
                if (u_bit == 9) begin
                    u_busy   <= 1'b0;
                    tx_ready <= 1'b1;
                    u_line   <= 1'b1;
                end else begin
                    u_bit  <= u_bit + 1;
                    u_line <= u_sh[u_bit+1];
                end
            end else begin
                u_div <= u_div + 1;
            end
        end else if (tx_we && tx_ready) begin
            u_busy   <= 1'b1;
            tx_ready <= 1'b0;
            u_sh     <= {1'b1, tx_data, 1'b0};
            u_line   <= 1'b0;
            u_bit    <= 0;
            u_div    <= 0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    logic [9:0] expq [$];
    logic [7:0] txlog [$];
    logic [7:0] rxlog [$];
    logic [N-1:0] gseq [$];
    int gap [N];
    bit stall [N];
    bit gaps_on = 1'b0;
    int m_ptr = 0;
    int n_we = 0;

    logic [N-1:0] s_grant, s_rdy;
    logic         s_we, s_busy;
    logic         s_prev_we = 1'b0;
    logic [7:0]   s_data;

    task automatic put(input int i, input logic [8:0] w);
        rq[i].push_back(w);
    endtask

    task automatic mput(input int i, input logic [8:0] w);
        rq[i].push_back(w);
        mq[i].push_back(w);
    endtask

    task automatic expect_b(input int i, input logic [7:0] b);
        expq.push_back({2'(i), b});
    endtask

    // message-level reference: whole messages, owner chosen round-robin
    task automatic run_model();
        int i;
        bit more;
        logic [8:0] w;
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int k = 0; k < N; k++)
                if (mq[k].size() > 0) more = 1'b1;
            if (more) begin
                i = -1;
                for (int k = 0; k < N; k++)
                    if (i < 0 && mq[(m_ptr + k) % N].size() > 0)
                        i = (m_ptr + k) % N;
                do begin
                    w = mq[i].pop_front();
                    expq.push_back({2'(i), w[7:0]});
                end while (!w[8]);
                m_ptr = (i + 1) % N;
            end
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && !stall[i] && gap[i] == 0) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = rq[i][0][7:0];
                req_last[i]         = rq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        logic [9:0] e;
        logic [8:0] w;
        @(negedge wb_clk);
        s_grant = grant;
        s_rdy   = req_ready;
        s_we    = tx_we;
        s_data  = tx_data;
        s_busy  = busy;
        if (s_we) begin
            n_we++;
            gseq.push_back(s_grant);
            chk("we_rdy", 32'(tx_ready), 1);
            chk("we_pulse", 32'(s_prev_we), 0);
            chk("we_busy", 32'(s_busy), 1);
            txlog.push_back(s_data);
            chk("exp_avail", 32'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("owner", 32'(s_grant), 32'(1) << e[9:8]);
                chk("ready", 32'(s_rdy), 32'(1) << e[9:8]);
                chk("data", 32'(s_data), 32'(e[7:0]));
            end
        end
        s_prev_we = s_we;
        @(posedge wb_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_rdy[i] && rq[i].size() > 0) begin
                w = rq[i].pop_front();
                if (gaps_on && !w[8]) gap[i] = $urandom_range(0, 50);
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
        apply();
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (k < bound && !(k > 1 && pending() == 0 && expq.size() == 0 &&
               txlog.size() == 0 && s_grant == '0 && tx_ready)) begin
            cyc();
            k++;
        end
        chk("idle_in_time", 32'(k < bound), 1);
    endtask

    task automatic wait_we(input int bound);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!s_we && k < bound);
        chk("we_in_time", 32'(s_we), 1);
    endtask

    initial begin : rx
        logic [7:0] b, t;
        forever begin
            @(negedge wb_clk);
            if (u_line == 1'b0) begin
                @(negedge wb_clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge wb_clk);
                    b[k] = u_line;
                end
                repeat (DIV) @(negedge wb_clk);
                chk("stop_bit", 32'(u_line), 1);
                rxlog.push_back(b);
                chk("rx_avail", 32'(txlog.size() > 0), 1);
                if (txlog.size() > 0) begin
                    t = txlog.pop_front();
                    chk("rx_byte", 32'(b), 32'(t));
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int c;
        int nm, len;
        for (int i = 0; i < N; i++) begin
            gap[i]   = 0;
            stall[i] = 1'b0;
        end
        repeat (3) cyc();
        wb_rst = 1'b0;
        cyc();
        chk("rst_grant", 32'(s_grant), 0);
        chk("rst_ready", 32'(s_rdy), 0);
        chk("rst_we", 32'(s_we), 0);
        chk("rst_data", 32'(s_data), 0);
        chk("rst_busy", 32'(s_busy), 0);

        // "Hi\n" from requester 0, latency and release timing
        rxlog.delete();
        mput(0, 9'h048);
        mput(0, 9'h069);
        mput(0, 9'h10A);
        run_model();
        apply();
        cyc();
        chk("lat_idle", 32'({s_grant, s_we}), 0);
        cyc();
        chk("lat_we", 32'(s_we), 1);
        chk("lat_grant", 32'(s_grant), 1);
        wait_we(200);
        wait_we(200);
        repeat (41) cyc();
        chk("hold_grant", 32'(s_grant), 1);
        cyc();
        chk("rel_grant", 32'(s_grant), 0);
        wait_idle(500);
        chk("hi_len", 32'(rxlog.size()), 3);
        if (rxlog.size() == 3)
            chk("hi_text", {8'h0, rxlog[0], rxlog[1], rxlog[2]}, 32'h0048690A);

        // two requesters with two-byte messages
        mput(0, 9'h0A0);
        mput(0, 9'h1A1);
        mput(1, 9'h0B0);
        mput(1, 9'h1B1);
        run_model();
        apply();
        wait_idle(1000);

        // owner 1 stalls mid-message; requester 0 waits through DRAIN
        put(1, 9'h0C1);
        put(1, 9'h0C2);
        put(1, 9'h1C3);
        expect_b(1, 8'hC1);
        expect_b(0, 8'hD1);
        expect_b(1, 8'hC2);
        expect_b(1, 8'hC3);
        apply();
        wait_we(200);
        put(0, 9'h1D1);
        stall[1] = 1'b1;
        apply();
        repeat (57) cyc();
        chk("to_hold", 32'(s_grant), 2);
        cyc();
        chk("to_drop", 32'(s_grant), 0);
        cyc();
        chk("to_next", 32'({s_grant, s_we}), 32'({3'b001, 1'b1}));
        stall[1] = 1'b0;
        apply();
        wait_idle(1000);

        // byte becomes valid on the expiry cycle: accepted, counter cleared
        put(1, 9'h0E1);
        put(1, 9'h0E2);
        put(1, 9'h1E3);
        expect_b(1, 8'hE1);
        expect_b(1, 8'hE2);
        expect_b(1, 8'hE3);
        apply();
        wait_we(200);
        stall[1] = 1'b1;
        apply();
        repeat (56) cyc();
        chk("ve_wait", 32'(s_grant), 2);
        stall[1] = 1'b0;
        apply();
        cyc();
        chk("ve_acc", 32'({s_grant, s_we}), 32'({3'b010, 1'b1}));
        stall[1] = 1'b1;
        apply();
        repeat (57) cyc();
        chk("ve_hold", 32'(s_grant), 2);
        cyc();
        chk("ve_drop", 32'(s_grant), 0);
        stall[1] = 1'b0;
        apply();
        wait_idle(1000);

        // reset three cycles after a write while the frame is on the line
        put(0, 9'h0F1);
        put(0, 9'h1F2);
        expect_b(0, 8'hF1);
        expect_b(0, 8'hF2);
        apply();
        wait_we(200);
        repeat (3) cyc();
        wb_rst = 1'b1;
        cyc();
        wb_rst = 1'b0;
        cyc();
        chk("mrst_grant", 32'(s_grant), 0);
        chk("mrst_ready", 32'(s_rdy), 0);
        chk("mrst_we", 32'(s_we), 0);
        chk("mrst_data", 32'(s_data), 0);
        chk("mrst_busy", 32'(s_busy), 0);
        c = 0;
        do begin
            cyc();
            c++;
        end while (!s_we && c < 100);
        chk("mrst_we_at", 32'(c), 36);
        wait_idle(1000);
        m_ptr = 1;

        // N=3 rotation, single-byte messages, from a fresh pointer
        wb_rst = 1'b1;
        cyc();
        wb_rst = 1'b0;
        m_ptr = 0;
        gseq.delete();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++)
                mput(i, {1'b1, 8'(i * 16 + r)});
        run_model();
        apply();
        wait_idle(2000);
        chk("rot_len", 32'(gseq.size()), 9);
        for (int j = 0; j < 9; j++)
            if (j < gseq.size())
                chk("rot_grant", 32'(gseq[j]), 32'(1) << (j % 3));

        // random messages with mid-message valid gaps
        gaps_on = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        mput(i, {b == len - 1, 8'($urandom)});
                end
            end
            run_model();
            apply();
            wait_idle(6000);
        end
        gaps_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
